// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM states and divider helper for the UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        longint denom;
        longint d;
        denom = longint'(baud) * longint'(os);
        d = (longint'(clk_hz) + denom / 2) / denom;
        if (d < 1) begin
            d = 1;
        end
        return int'(d);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick divider with synchronous clear
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count DIV clocks per tick; clear restarts the phase at a start edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote and error flags
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] T_S0   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] T_S1   = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] T_DEC  = OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [OSW-1:0] T_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

    rx_state_t state, state_n;

    logic                 rx_meta, rs, rs_prev;
    logic                 tick;
    logic [OSW-1:0]       os_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 s0, s1;
    logic                 zero_acc, frm_acc, par_acc;
    logic                 decide, vote, start_det, complete, brk, load;

    assign decide = tick && (os_cnt == T_DEC);
    assign vote   = (s0 & s1) | (s0 & rs) | (s1 & rs);
    assign load   = complete && (!rx_valid || rx_ready);
    assign busy   = (state != ST_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .tick (tick)
    );

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
            rs_prev <= rs;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle event strobes; bits resolve on the decision tick.
    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        complete  = 1'b0;
        brk       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rs_prev && !rs) begin
                    state_n   = ST_START;
                    start_det = 1'b1;
                end
            end
            ST_START: begin
                if (decide) begin
                    state_n = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide && bit_cnt == LAST_DATA) begin
                    state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                if (decide) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (bit_cnt == 4'd0 && zero_acc && !vote) begin
                        brk     = 1'b1;
                        state_n = ST_BRK_WAIT;
                    end else if (bit_cnt == LAST_STOP) begin
                        complete = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (rs) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Oversample position within the current bit, and the two early vote samples.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE || state == ST_BRK_WAIT) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= (os_cnt == T_LAST) ? '0 : os_cnt + 1'b1;
        end
        if (rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else if (tick) begin
            if (os_cnt == T_S0) s0 <= rs;
            if (os_cnt == T_S1) s1 <= rs;
        end
    end

    // Bit counter, data shift register and per-frame error/break accumulators.
    always_ff @(posedge clk) begin
        if (rst || state_n != state) begin
            bit_cnt <= '0;
        end else if (decide && (state == ST_DATA || state == ST_STOP)) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
        if (rst) begin
            shreg    <= '0;
            zero_acc <= 1'b0;
            frm_acc  <= 1'b0;
            par_acc  <= 1'b0;
        end else if (start_det) begin
            zero_acc <= 1'b1;
            frm_acc  <= 1'b0;
            par_acc  <= 1'b0;
        end else if (decide) begin
            if (state == ST_DATA) begin
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            end
            if (state == ST_DATA || state == ST_PAR) begin
                zero_acc <= zero_acc & ~vote;
            end
            if (state == ST_PAR) begin
                par_acc <= (PARITY == PAR_ODD) ? ~(^shreg ^ vote) : (^shreg ^ vote);
            end
            if (state == ST_STOP) begin
                frm_acc <= frm_acc | ~vote;
            end
        end
    end

    // Output holding register with valid/ready handshake and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= complete && rx_valid && !rx_ready;
            break_det <= brk;
            if (load) begin
                rx_data    <= shreg;
                frame_err  <= frm_acc | ~vote;
                parity_err <= par_acc;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
